// File: rtl/round_robin_mux_4.sv
// Four-channel round-robin multiplexer with a registered output stage.
// Grant search starts one past the last served channel and wraps 3 -> 0.
module round_robin_mux_4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    input  logic               out_ready
);

    logic [1:0] last;
    logic [1:0] gidx;
    logic [3:0] grant;
    logic       found;
    logic       load_en;

    always_comb begin
        logic [1:0] idx;
        grant = 4'b0000;
        gidx  = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = last + 2'd1 + 2'(i);
            if (!found && in_valid[idx]) begin
                found      = 1'b1;
                gidx       = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    assign load_en = !out_valid || out_ready;

    // Ready is masked by reset so nothing is accepted while rst_n is low.
    assign in_ready = (rst_n && load_en) ? grant : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            last      <= 2'd3;
        end else if (load_en) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gidx)*WIDTH +: WIDTH];
                out_sel   <= gidx;
                last      <= gidx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
